regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DW, default 32, register data width in bits.
REQ-002 SHALL provide parameter AW, default 5, address width; depth is 2**AW entries.
REQ-003 SHALL provide parameter NRD, default 2, number of independent read ports (range 1..4).
REQ-004 SHALL provide port clk  input  1  single clock, all state changes on its rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL provide port re  input  1  global read enable; when 0, all rd lanes read 0.
REQ-007 SHALL provide port ra  input  NRD*AW  read addresses; lane k occupies bits [k*AW +: AW].
REQ-008 SHALL provide port rd  output  NRD*DW  read data; lane k occupies bits [k*DW +: DW].
REQ-009 SHALL provide port rbusy  output  NRD  lane k is 1 when ra lane k has a pending write.
REQ-010 SHALL provide port we, wa, wd  input  1/AW/DW  write enable, write address, write data.
REQ-011 SHALL provide port iss, ia  input  1/AW  issue strobe and address; marks ia as pending-write.
REQ-012 SHALL provide port dump_req  input  1  one-cycle pulse that starts a register dump.
REQ-013 SHALL provide port dump_vld, dump_idx, dump_data, dump_done  output  1/AW/DW/1  dump stream.

Function
REQ-014 SHALL perform the write as mem[wa] <= wd on the rising clk edge when we=1 and wa!=0.
REQ-015 SHALL read entry 0 as 0 on every lane and SHALL ignore writes to entry 0.
REQ-016 SHALL read combinationally: rd lane k = 0 if re=0 or ra lane k=0, else mem[ra lane k].
REQ-017 SHALL keep a busy bit per entry: set on the edge where iss=1 and ia!=0, cleared on the edge where we=1 to that entry.
REQ-018 SHALL give set priority over clear when iss and we target the same entry in the same cycle; the result is busy=1.
REQ-019 SHALL never mark entry 0 busy; rbusy lane k = busy[ra lane k], and it is 0 when ra lane k=0.
REQ-020 SHALL run the dump FSM with states IDLE, RUN and DONE.
REQ-021 SHALL move IDLE->RUN on dump_req=1; in RUN, dump_vld=1 and dump_idx increments from 0 to 2**AW-1, one entry per cycle.
REQ-022 SHALL drive dump_data = mem[dump_idx] as held in that cycle, ignoring any write landing at the same edge.
REQ-023 SHALL move RUN->DONE after index 2**AW-1; in DONE, dump_done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-024 SHALL ignore dump_req while the FSM is in RUN or DONE; dump_idx does not wrap past the last entry.
REQ-025 SHALL drive dump_data=0 for idx 0, and dump_data=0 whenever dump_vld=0.

Reset
REQ-026 SHALL, on rst=0 and without waiting for clk, clear all entries, clear all busy bits, force the FSM to IDLE, and drive dump_idx=0, dump_vld=0 and dump_done=0.
REQ-027 SHALL, if rst is asserted during RUN, abort the dump with no dump_done pulse.
REQ-028 SHALL ignore writes, issues and dump_req while rst=0.

Configuration
REQ-029 SHALL compile in write-to-read forwarding when RF_BYPASS_EN is defined: when we=1, wa!=0, re=1 and wa equals ra lane k, rd lane k = wd in the same cycle and rbusy lane k = 0 (unless iss hits the same address, per REQ-018).
REQ-030 SHALL, without RF_BYPASS_EN, return the pre-write value and the registered busy bit until the edge after the write.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default DW/AW/NRD constants in the shared global definitions include.
REQ-032 SHALL implement the dump FSM as sub-module regfile_dump_seq; storage, busy bits and read lanes stay in regfile_mp.

Verification
REQ-033 SHALL cover write then read: we=1 wa=3 wd=0xDEADBEEF; the next cycle ra lane 0=3 with re=1 gives rd lane 0=0xDEADBEEF, and re=0 gives 0.
REQ-034 SHALL cover entry zero: we=1 wa=0 wd=0x12345678, then ra=0 gives rd=0 and rbusy=0 on every lane.
REQ-035 SHALL cover forwarding: same-cycle we=1 wa=5 wd=0xA5A5A5A5 with ra lane 1=5; with RF_BYPASS_EN rd lane 1=0xA5A5A5A5, without it rd lane 1=0.
REQ-036 SHALL cover the scoreboard: iss ia=7, giving rbusy=1; then iss ia=7 together with we wa=7 in one cycle, giving busy still 1; then we wa=7 alone, giving rbusy=0.
REQ-037 SHALL cover a full dump: after writing mem[i]=i*0x11 for i=1..31, pulse dump_req; expect 32 consecutive dump_vld cycles (idx 0..31, data 0 then i*0x11), then one dump_done cycle, and a second dump_req mid-run is ignored.
REQ-038 SHALL cover reset mid-dump: assert rst at idx 10; outputs clear immediately, no dump_done pulse, and all entries read 0 afterwards.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry and
// the dump sequencer state encoding.
package regfile_mp_pkg;

  localparam int unsigned RF_DW  = 32;
  localparam int unsigned RF_AW  = 5;
  localparam int unsigned RF_NRD = 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks every register index once per dump request, then
// pulses done for a single cycle. Requests arriving mid-dump are dropped.
module regfile_dump_seq
  import regfile_mp_pkg::*;
#(
  parameter int unsigned AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_req,
  output logic          dump_vld,
  output logic          dump_done,
  output logic [AW-1:0] dump_idx
);

  localparam logic [AW-1:0] LastIdx = '1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // Next-state: the index saturates at the last entry instead of wrapping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // State register; reset aborts any dump in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decoded straight from state so they clear with reset.
  always_comb begin
    dump_vld  = (state_q == StRun);
    dump_done = (state_q == StDone);
    dump_idx  = idx_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a pending-write scoreboard and a
// register dump stream. Entry 0 is hard-wired to zero and never busy.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW  = RF_DW,
  parameter int unsigned AW  = RF_AW,
  parameter int unsigned NRD = RF_NRD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DW-1:0]     wd,
  input  logic              iss,
  input  logic [AW-1:0]     ia,
  input  logic              dump_req,
  output logic              dump_vld,
  output logic [AW-1:0]     dump_idx,
  output logic [DW-1:0]     dump_data,
  output logic              dump_done
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic             wr_en;

  assign wr_en = we && (wa != '0);

  // Storage; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  // Scoreboard next-state: clear applied first so a same-entry issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wa] = 1'b0;
    end
    if (iss && (ia != '0)) begin
      busy_d[ia] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lane
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];

    // Read lane k: combinational, zero for entry 0 or when reads are off.
    always_comb begin
      rd[k*DW +: DW] = '0;
      rbusy[k]       = 1'b0;
      if (ra_k != '0) begin
        rbusy[k] = busy_q[ra_k];
        if (re) begin
          rd[k*DW +: DW] = mem_q[ra_k];
        end
`ifdef RF_BYPASS_EN
        if (re && wr_en && (wa == ra_k)) begin
          rd[k*DW +: DW] = wd;
          rbusy[k]       = iss && (ia == ra_k);
        end
`endif
      end
    end
  end

  regfile_dump_seq #(
    .AW (AW)
  ) u_dump_seq (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .dump_vld  (dump_vld),
    .dump_done (dump_done),
    .dump_idx  (dump_idx)
  );

  // Dump data reflects the stored value before any write at this edge.
  always_comb begin
    dump_data = '0;
    if (dump_vld && (dump_idx != '0)) begin
      dump_data = mem_q[dump_idx];
    end
  end

endmodule
